// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// pwm_fade_ctrl : steps a pwm level toward commanded targets once per PWM period, then holds. rev 1.0
// Optional build macro PWM_FADE_LOOP_EN adds loop_en for continuous start<->target fading.
module pwm_fade_ctrl #(
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [WIDTH-1:0]  cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
`ifdef PWM_FADE_LOOP_EN
  input  logic              loop_en,
`endif
  output logic [WIDTH-1:0]  level,
  output logic              busy,
  output logic              done,
  output logic              period_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  pcnt;
  logic [WIDTH-1:0]  target, target_nxt;
  logic [WIDTH-1:0]  step, step_nxt;
  logic [WIDTH-1:0]  level_nxt, ramp_level;
  logic [WIDTH:0]    sum;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              accept, done_nxt;
`ifdef PWM_FADE_LOOP_EN
  logic [WIDTH-1:0]  start, start_nxt;
`endif

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready & ~abort;

  // One saturating step toward target; the extra sum bit prevents wrap past all-ones.
  always_comb begin
    sum        = {1'b0, level} + {1'b0, step};
    ramp_level = level;
    if (level < target) begin
      ramp_level = (sum > {1'b0, target}) ? target : sum[WIDTH-1:0];
    end else if (level > target) begin
      ramp_level = ((level - target) <= step) ? target : (level - step);
    end
  end

  always_comb begin
    state_nxt    = state;
    level_nxt    = level;
    target_nxt   = target;
    step_nxt     = step;
    hold_nxt     = hold;
    hold_cnt_nxt = hold_cnt;
    done_nxt     = 1'b0;
`ifdef PWM_FADE_LOOP_EN
    start_nxt    = start;
`endif
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target_nxt = cmd_target;
            step_nxt   = (cmd_step == '0) ? WIDTH'(1) : cmd_step;
            hold_nxt   = cmd_hold;
            state_nxt  = RAMP;
`ifdef PWM_FADE_LOOP_EN
            start_nxt  = level;
`endif
          end
        end
        RAMP: begin
          if (period_tick) begin
            level_nxt = ramp_level;
            if (ramp_level == target) begin
              state_nxt    = HOLD;
              hold_cnt_nxt = hold;
            end
          end
        end
        HOLD: begin
          if (period_tick) begin
            if (hold_cnt != '0) begin
              hold_cnt_nxt = hold_cnt - HOLD_W'(1);
            end else begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
`ifdef PWM_FADE_LOOP_EN
              if (loop_en) begin
                state_nxt  = RAMP;
                target_nxt = start;
                start_nxt  = target;
              end
`endif
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt        <= '0;
      period_tick <= 1'b0;
      state       <= IDLE;
      level       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      target      <= '0;
      step        <= '0;
      hold        <= '0;
      hold_cnt    <= '0;
`ifdef PWM_FADE_LOOP_EN
      start       <= '0;
`endif
    end else begin
      pcnt        <= pcnt + WIDTH'(1);
      period_tick <= &pcnt;
      state       <= state_nxt;
      level       <= level_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= done_nxt;
      target      <= target_nxt;
      step        <= step_nxt;
      hold        <= hold_nxt;
      hold_cnt    <= hold_cnt_nxt;
`ifdef PWM_FADE_LOOP_EN
      start       <= start_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// tb_pwm_fade_ctrl : scoreboard bench; per-tick expected levels are queued at command issue
// and popped by a monitor after each PWM period tick seen while busy.
module tb_pwm_fade_ctrl;
  localparam int WIDTH  = 4;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_target;
  logic [WIDTH-1:0]  cmd_step;
  logic [HOLD_W-1:0] cmd_hold;
  logic              abort;
  logic [WIDTH-1:0]  level;
  logic              busy;
  logic              done;
  logic              period_tick;
`ifdef PWM_FADE_LOOP_EN
  logic              loop_en = 1'b0;
`endif

  pwm_fade_ctrl #(.WIDTH(WIDTH), .HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_hold    (cmd_hold),
    .abort       (abort),
`ifdef PWM_FADE_LOOP_EN
    .loop_en     (loop_en),
`endif
    .level       (level),
    .busy        (busy),
    .done        (done),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    bit last;
  } exp_t;

  exp_t trq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_level = 0;     // last level confirmed by the monitor
  int   plan_level = 0;  // level the model expects once all queued ticks complete

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list the level after every tick the command occupies.
  function automatic void push_trace(input int t, input int s, input int h);
    int cur;
    int se;
    exp_t e;
    cur = plan_level;
    se  = (s == 0) ? 1 : s;
    if (cur == t) begin
      e.lvl = cur; e.last = 1'b0; trq.push_back(e);
    end else begin
      while (cur != t) begin
        if (cur < t) cur = (cur + se > t) ? t : cur + se;
        else         cur = (cur - t <= se) ? t : cur - se;
        e.lvl = cur; e.last = 1'b0; trq.push_back(e);
      end
    end
    for (int i = 0; i <= h; i++) begin
      e.lvl = cur; e.last = (i == h); trq.push_back(e);
    end
    plan_level = cur;
  endfunction

  // Called at a negedge; presents the command until the DUT is ready, then accepts it.
  task automatic send(input int t, input int s, input int h);
    bit ok;
    cmd_target = WIDTH'(t);
    cmd_step   = WIDTH'(s);
    cmd_hold   = HOLD_W'(h);
    cmd_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("send_ready_timeout", int'(ok), 1);
    if (ok) push_trace(t, s, h);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (trq.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", int'(ok), 1);
    if (!ok) trq.delete();
  endtask

  initial begin : monitor
    bit   tick_busy_q;
    exp_t e;
    tick_busy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tick_busy_q = 1'b0;
      end else begin
        if (tick_busy_q) begin
          if (trq.size() == 0) begin
            chk("unexpected_tick_update", 1, 0);
          end else begin
            e = trq.pop_front();
            chk("trace_level", int'(level), e.lvl);
            chk("trace_done", int'(done), int'(e.last));
            chk("trace_busy", int'(busy), int'(!e.last));
            m_level = e.lvl;
          end
        end else begin
          chk("stray_done", int'(done), 0);
        end
        tick_busy_q = period_tick && busy;
      end
    end
  end

  initial begin
    bit ok;
    int t;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_step   = '0;
    cmd_hold   = '0;
    abort      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_tick", int'(period_tick), 0);
    reset = 1'b0;

    // Period tick: high after edge 16, 32, ... counted from reset release.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("period_tick", int'(period_tick), int'(k % 16 == 0));
    end

    send(10, 3, 2);  wait_idle();
    chk("t2_final", int'(level), 10);
    send(1, 4, 0);   wait_idle();
    chk("t3_final", int'(level), 1);
    send(1, 0, 0);   wait_idle();
    chk("t4_same", int'(level), 1);
    send(14, 15, 0); wait_idle();
    send(15, 15, 0); wait_idle();
    chk("t4_sat", int'(level), 15);

    // Abort mid-ramp at level 6 with a second command held valid during the ramp.
    send(0, 15, 0);  wait_idle();
    send(15, 3, 0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (m_level == 6) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach6_timeout", int'(ok), 1);
    cmd_target = 4'd2; cmd_step = 4'd1; cmd_hold = 4'd1; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_not_taken", int'(cmd_ready), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_level", int'(level), 6);
    chk("abort_done", int'(done), 0);
    trq.delete();
    plan_level = 6;
    push_trace(2, 1, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    wait_idle();
    chk("after_abort_final", int'(level), 2);

    // Random commands, issued back-to-back so each is taken on return to IDLE.
    for (int n = 0; n < 24; n++) begin
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
      if (n % 6 == 5) wait_idle();
    end
    wait_idle();

    // Async reset in HOLD clears level and busy without a clock edge.
    t = (plan_level == 9) ? 5 : 9;
    send(t, 15, 3);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (trq.size() == 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach_hold_timeout", int'(ok), 1);
    chk("hold_level", int'(level), t);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_level", int'(level), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    trq.delete();
    plan_level = 0;
    m_level = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_level", int'(level), 0);
    send(7, 2, 1); wait_idle();
    chk("post_reset_final", int'(level), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
